// File: rtl/hv_bind_pkg.sv
// Shared types for the hypervector bind sequencer: bind modes, FSM states and
// the chunk-count helper used at command accept.
package hv_bind_pkg;

  localparam int HV_DATA_WIDTH_DEF          = 32;
  localparam int HV_ADDRESS_WIDTH_DEF       = 5;
  localparam int MAX_HYPERVECTOR_LENGTH_DEF = 8;
  localparam int NUM_PARALLEL_KERNELS_DEF   = 4;

  typedef enum logic [1:0] {
    MUL  = 2'd0,
    XOR  = 2'd1,
    ADD  = 2'd2,
    RSVD = 2'd3
  } bind_mode_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_A = 3'd1,
    RD_B = 3'd2,
    WR   = 3'd3,
    DONE = 3'd4
  } state_e;

  // Number of P-wide chunks needed to cover len elements.
  function automatic int unsigned chunk_count(input int unsigned len, input int unsigned lanes);
    return (len + lanes - 1) / lanes;
  endfunction

endpackage

// File: rtl/hv_bind_sequencer_if.sv
// Command handshake plus the P-port RAM bus of the bind sequencer.
// slave = sequencer view, master = command decoder / RAM side view.
interface hv_bind_sequencer_if #(
  parameter int HV_DATA_WIDTH        = 32,
  parameter int HV_ADDRESS_WIDTH     = 5,
  parameter int NUM_PARALLEL_KERNELS = 4
) ();

  // start/ready: a command transfers on a rising edge where start && ready;
  // start is ignored while ready is low and command inputs are only sampled
  // on that transfer edge. done pulses once per accepted command and error
  // is meaningful only while done is high.
  logic                                                   start;
  logic                                                   ready;
  logic [1:0]                                             mode;
  logic [HV_ADDRESS_WIDTH:0]                              vec_length;
  logic [HV_ADDRESS_WIDTH-1:0]                            hva;
  logic [HV_ADDRESS_WIDTH-1:0]                            hvb;
  logic [HV_ADDRESS_WIDTH-1:0]                            hvc;
  logic [HV_ADDRESS_WIDTH-1:0]                            shift;
  logic                                                   done;
  logic                                                   error;
  logic [NUM_PARALLEL_KERNELS-1:0]                        we_n;
  logic [NUM_PARALLEL_KERNELS-1:0][HV_ADDRESS_WIDTH-1:0]  address;
  logic [NUM_PARALLEL_KERNELS-1:0][HV_DATA_WIDTH-1:0]     data_wr;
  logic [NUM_PARALLEL_KERNELS-1:0][HV_DATA_WIDTH-1:0]     data_rd;

  modport slave (
    input  start, mode, vec_length, hva, hvb, hvc, shift, data_rd,
    output ready, done, error, we_n, address, data_wr
  );

  modport master (
    output start, mode, vec_length, hva, hvb, hvc, shift, data_rd,
    input  ready, done, error, we_n, address, data_wr
  );

endinterface

// File: rtl/hv_bind_alu.sv
// One combinational bind lane: y = op(a, b) selected by the bind mode.
// The reserved mode yields zero; it never reaches a write.
module hv_bind_alu
  import hv_bind_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  bind_mode_e   mode,
  output logic [W-1:0] y
);

  always_comb begin
    y = '0;
    unique case (mode)
      MUL:     y = a * b;
      XOR:     y = a ^ b;
      ADD:     y = a + b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/hv_bind_sequencer.sv
// Hypervector bind sequencer: C[i] = op(A[i], B[i]) over a P-port RAM, one lane
// per port. Optional macro HV_BIND_PERMUTE_EN reads B cyclically rotated by shift.
module hv_bind_sequencer
  import hv_bind_pkg::*;
#(
  parameter int HV_DATA_WIDTH          = HV_DATA_WIDTH_DEF,
  parameter int HV_ADDRESS_WIDTH       = HV_ADDRESS_WIDTH_DEF,
  parameter int MAX_HYPERVECTOR_LENGTH = MAX_HYPERVECTOR_LENGTH_DEF,
  parameter int NUM_PARALLEL_KERNELS   = NUM_PARALLEL_KERNELS_DEF
) (
  input  logic                clk,
  input  logic                reset,
  hv_bind_sequencer_if.slave  bus,
  output state_e              dbg_state
);

  localparam int DW = HV_DATA_WIDTH;
  localparam int AW = HV_ADDRESS_WIDTH;
  localparam int P  = NUM_PARALLEL_KERNELS;
  localparam int LW = AW + 1;
  localparam int IW = LW + $clog2(P) + 1;
  localparam logic [LW-1:0] MAX_LEN = LW'(MAX_HYPERVECTOR_LENGTH);

  state_e                 state_q, state_d;
  logic [LW-1:0]          k_q, k_d;
  logic [LW-1:0]          nchunk_q, nchunk_d;
  logic [LW-1:0]          len_q, len_d;
  bind_mode_e             mode_q, mode_d;
  logic [AW-1:0]          hva_q, hva_d;
  logic [AW-1:0]          hvb_q, hvb_d;
  logic [AW-1:0]          hvc_q, hvc_d;
  logic [P-1:0][DW-1:0]   a_q, a_d;
  logic                   ready_q, ready_d;
  logic                   done_q, done_d;
  logic                   error_q, error_d;
`ifdef HV_BIND_PERMUTE_EN
  logic [AW-1:0]          shift_q, shift_d;
  logic [IW-1:0]          lane_bsum;
`endif

  logic                   len_zero, len_bad, mode_bad, shift_bad, cmd_err;
  logic [P-1:0][IW-1:0]   lane_idx;
  logic [P-1:0][IW-1:0]   lane_bidx;
  logic [P-1:0]           lane_act;
  logic [P-1:0][DW-1:0]   alu_y;
  logic [P-1:0]           we_n_c;
  logic [P-1:0][AW-1:0]   address_c;
  logic [P-1:0][DW-1:0]   data_wr_c;

  // Validation of the command presented on the bus, used only on accept.
  always_comb begin
    len_zero  = (bus.vec_length == '0);
    len_bad   = (bus.vec_length > MAX_LEN);
    mode_bad  = (bind_mode_e'(bus.mode) == RSVD);
`ifdef HV_BIND_PERMUTE_EN
    shift_bad = !len_zero && ({1'b0, bus.shift} >= bus.vec_length);
`else
    shift_bad = 1'b0;
`endif
    cmd_err   = mode_bad || len_bad || shift_bad;
  end

  // Element index per lane for the current chunk, plus the B-side index.
  always_comb begin
    lane_idx  = '0;
    lane_bidx = '0;
    lane_act  = '0;
`ifdef HV_BIND_PERMUTE_EN
    lane_bsum = '0;
`endif
    for (int j = 0; j < P; j++) begin
      lane_idx[j] = IW'(k_q) * IW'(P) + IW'(j);
      lane_act[j] = (lane_idx[j] < IW'(len_q));
`ifdef HV_BIND_PERMUTE_EN
      // Both terms are below len, so one conditional subtract is the modulo.
      lane_bsum    = lane_idx[j] + IW'(shift_q);
      lane_bidx[j] = (lane_bsum >= IW'(len_q)) ? (lane_bsum - IW'(len_q)) : lane_bsum;
`else
      lane_bidx[j] = lane_idx[j];
`endif
    end
  end

  for (genvar g = 0; g < P; g++) begin : g_lane
    hv_bind_alu #(.W(DW)) u_alu (
      .a    (a_q[g]),
      .b    (bus.data_rd[g]),
      .mode (mode_q),
      .y    (alu_y[g])
    );
  end

  // RAM port drive; inactive lanes and non-access states present all zeros.
  always_comb begin
    we_n_c    = '1;
    address_c = '0;
    data_wr_c = '0;
    for (int j = 0; j < P; j++) begin
      if (lane_act[j]) begin
        unique case (state_q)
          RD_A: address_c[j] = hva_q + AW'(lane_idx[j]);
          RD_B: address_c[j] = hvb_q + AW'(lane_bidx[j]);
          WR: begin
            address_c[j] = hvc_q + AW'(lane_idx[j]);
            we_n_c[j]    = 1'b0;
            data_wr_c[j] = alu_y[j];
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    nchunk_d = nchunk_q;
    len_d    = len_q;
    mode_d   = mode_q;
    hva_d    = hva_q;
    hvb_d    = hvb_q;
    hvc_d    = hvc_q;
    a_d      = a_q;
    ready_d  = ready_q;
    done_d   = 1'b0;
    error_d  = 1'b0;
`ifdef HV_BIND_PERMUTE_EN
    shift_d  = shift_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.start && ready_q) begin
          k_d      = '0;
          len_d    = bus.vec_length;
          nchunk_d = LW'(chunk_count(32'(bus.vec_length), 32'(P)));
          mode_d   = bind_mode_e'(bus.mode);
          hva_d    = bus.hva;
          hvb_d    = bus.hvb;
          hvc_d    = bus.hvc;
`ifdef HV_BIND_PERMUTE_EN
          shift_d  = bus.shift;
`endif
          ready_d  = 1'b0;
          if (cmd_err || len_zero) begin
            state_d = DONE;
            done_d  = 1'b1;
            error_d = cmd_err;
          end else begin
            state_d = RD_A;
          end
        end
      end
      RD_A: state_d = RD_B;
      RD_B: begin
        // data_rd now carries A from the addresses presented in RD_A.
        for (int j = 0; j < P; j++) begin
          a_d[j] = lane_act[j] ? bus.data_rd[j] : '0;
        end
        state_d = WR;
      end
      WR: begin
        if ((k_q + LW'(1)) < nchunk_q) begin
          k_d     = k_q + LW'(1);
          state_d = RD_A;
        end else begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      k_q      <= '0;
      nchunk_q <= '0;
      len_q    <= '0;
      mode_q   <= MUL;
      hva_q    <= '0;
      hvb_q    <= '0;
      hvc_q    <= '0;
      a_q      <= '0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
`ifdef HV_BIND_PERMUTE_EN
      shift_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      nchunk_q <= nchunk_d;
      len_q    <= len_d;
      mode_q   <= mode_d;
      hva_q    <= hva_d;
      hvb_q    <= hvb_d;
      hvc_q    <= hvc_d;
      a_q      <= a_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
      error_q  <= error_d;
`ifdef HV_BIND_PERMUTE_EN
      shift_q  <= shift_d;
`endif
    end
  end

  assign bus.ready   = ready_q;
  assign bus.done    = done_q;
  assign bus.error   = error_q;
  assign bus.we_n    = we_n_c;
  assign bus.address = address_c;
  assign bus.data_wr = data_wr_c;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_hv_bind_sequencer.sv
// Self-checking bench for hv_bind_sequencer: directed spec scenarios plus random
// commands against a chunk-level reference model. HV_BIND_PERMUTE_EN adds the rotation test.
module tb_hv_bind_sequencer;
  import hv_bind_pkg::*;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int P     = 4;
  localparam int MAXL  = 8;
  localparam int DEPTH = 1 << AW;
  localparam int LW    = AW + 1;
  localparam int WR_W  = AW + DW;
`ifdef HV_BIND_PERMUTE_EN
  localparam bit PERMUTE = 1'b1;
`else
  localparam bit PERMUTE = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic load_req = 1'b0;
  state_e dbg_state;
  int checks = 0;
  int failures = 0;
  logic [DW-1:0] ram   [DEPTH];
  logic [DW-1:0] img   [DEPTH];
  logic [DW-1:0] mem_m [DEPTH];
  logic [WR_W-1:0] exp_q[$];
  logic [WR_W-1:0] obs_q[$];

  // ---------------- clock / reset / DUT ----------------
  always #5 clk = ~clk;

  hv_bind_sequencer_if #(.HV_DATA_WIDTH(DW), .HV_ADDRESS_WIDTH(AW), .NUM_PARALLEL_KERNELS(P)) bus ();

  hv_bind_sequencer #(
    .HV_DATA_WIDTH(DW), .HV_ADDRESS_WIDTH(AW),
    .MAX_HYPERVECTOR_LENGTH(MAXL), .NUM_PARALLEL_KERNELS(P)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus), .dbg_state(dbg_state)
  );

  // P-port RAM, 1-cycle read latency, read returns the pre-write value.
  always @(posedge clk) begin
    for (int j = 0; j < P; j++) bus.data_rd[j] <= ram[bus.address[j]];
    if (load_req) begin
      for (int a = 0; a < DEPTH; a++) ram[a] <= img[a];
    end else begin
      for (int j = 0; j < P; j++)
        if (bus.we_n[j] == 1'b0) ram[bus.address[j]] <= bus.data_wr[j];
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic logic [DW-1:0] bind_op(input int m, input logic [DW-1:0] a, input logic [DW-1:0] b);
    case (m)
      0:       return a * b;
      1:       return a ^ b;
      default: return a + b;
    endcase
  endfunction

  function automatic int b_index(input int i, input int len, input int s);
    return PERMUTE ? (i + s) % len : i;
  endfunction

  function automatic bit is_err(input int m, input int len, input int s);
    return (m == 3) || (len > MAXL) || (PERMUTE && len != 0 && s >= len);
  endfunction

  // Each chunk reads all its operands before any of its writes land.
  task automatic model_cmd(input int m, input int len, input int a, input int b, input int c,
                           input int s, output logic e, output int dc);
    logic [DW-1:0] res [P];
    int nch;
    exp_q.delete();
    e = is_err(m, len, s);
    if (e || len == 0) begin
      dc = 1;
      return;
    end
    nch = (len + P - 1) / P;
    dc  = 3 * nch + 1;
    for (int k = 0; k < nch; k++) begin
      for (int j = 0; j < P; j++)
        if (k * P + j < len)
          res[j] = bind_op(m, mem_m[(a + k * P + j) % DEPTH], mem_m[(b + b_index(k * P + j, len, s)) % DEPTH]);
      for (int j = 0; j < P; j++)
        if (k * P + j < len) begin
          mem_m[(c + k * P + j) % DEPTH] = res[j];
          exp_q.push_back({AW'(c + k * P + j), res[j]});
        end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic fill_img();
    for (int a = 0; a < DEPTH; a++) img[a] = $urandom;
  endtask

  task automatic load_ram();
    @(negedge clk);
    load_req = 1'b1;
    @(posedge clk);
    #1 load_req = 1'b0;
    for (int a = 0; a < DEPTH; a++) mem_m[a] = img[a];
  endtask

  task automatic drive_cmd(input int m, input int len, input int a, input int b, input int c, input int s);
    bus.start      = 1'b1;
    bus.mode       = 2'(m);
    bus.vec_length = LW'(len);
    bus.hva        = AW'(a);
    bus.hvb        = AW'(b);
    bus.hvc        = AW'(c);
    bus.shift      = AW'(s);
  endtask

  // Issues one command and records what the bus did; prot_bad counts cycles
  // where ready, per-lane address/we_n or idle-lane data_wr broke the rules.
  task automatic run_cmd(input int m, input int len, input int a, input int b, input int c, input int s,
                         output int done_cyc, output logic err_o, output int prot_bad);
    int nch, ch, ph, i;
    logic [AW-1:0] ea;
    logic ewe;
    nch = (is_err(m, len, s) || len == 0) ? 0 : (len + P - 1) / P;
    obs_q.delete();
    done_cyc = -1;
    err_o    = 1'bx;
    prot_bad = 0;
    @(negedge clk);
    drive_cmd(m, len, a, b, c, s);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    drive_cmd($urandom_range(0, 3), $urandom_range(0, 9), $urandom, $urandom, $urandom, $urandom);
    bus.start = 1'b0;
    for (int cyc = 1; cyc <= 40 && done_cyc < 0; cyc++) begin
      @(negedge clk);
      if (bus.ready !== 1'b0) prot_bad++;
      ch = (cyc - 1) / 3;
      ph = (cyc - 1) % 3;
      for (int j = 0; j < P; j++) begin
        i   = ch * P + j;
        ea  = '0;
        ewe = 1'b1;
        if (ch < nch && i < len) begin
          case (ph)
            0:       ea = AW'(a + i);
            1:       ea = AW'(b + b_index(i, len, s));
            default: begin ea = AW'(c + i); ewe = 1'b0; end
          endcase
        end
        if (bus.address[j] !== ea || bus.we_n[j] !== ewe) prot_bad++;
        if (bus.we_n[j] === 1'b1 && bus.data_wr[j] !== '0) prot_bad++;
        if (bus.we_n[j] === 1'b0) obs_q.push_back({bus.address[j], bus.data_wr[j]});
      end
      if (bus.done === 1'b1) begin
        done_cyc = cyc;
        err_o    = bus.error;
      end
    end
    @(negedge clk);
    if (bus.ready !== 1'b1 || bus.done !== 1'b0) prot_bad++;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    drive_cmd(0, 0, 0, 0, 0, 0);
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", bus.ready); end
    checks++; if (bus.done !== 1'b0 || bus.error !== 1'b0) begin failures++; $display("FAIL reset_done_err got=%b/%b exp=0/0", bus.done, bus.error); end
    checks++; if (bus.we_n !== '1) begin failures++; $display("FAIL reset_we_n got=%b exp=all ones", bus.we_n); end
    checks++; if (bus.address !== '0 || bus.data_wr !== '0) begin failures++; $display("FAIL reset_addr_data got=%h/%h exp=0", bus.address, bus.data_wr); end
    checks++; if (dbg_state !== IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, IDLE); end
    reset = 1'b0;
  endtask

  task automatic test_mul();
    logic [DW-1:0] exp_c [4] = '{32'd5, 32'd12, 32'd21, 32'd32};
    int dc, pb, nbad;
    logic er;
    fill_img();
    for (int i = 0; i < 4; i++) begin img[i] = DW'(i + 1); img[8 + i] = DW'(i + 5); end
    load_ram();
    run_cmd(0, 4, 0, 8, 16, 0, dc, er, pb);
    checks++; if (dc !== 4) begin failures++; $display("FAIL mul_done_cycle got=%0d exp=4", dc); end
    checks++; if (er !== 1'b0) begin failures++; $display("FAIL mul_error got=%b exp=0", er); end
    nbad = 0;
    for (int i = 0; i < 4; i++) if (ram[16 + i] !== exp_c[i]) nbad++;
    checks++; if (nbad != 0) begin failures++; $display("FAIL mul_ram got=%0d,%0d,%0d,%0d exp=5,12,21,32", ram[16], ram[17], ram[18], ram[19]); end
    checks++; if (pb != 0 || ram[20] !== img[20]) begin failures++; $display("FAIL mul_protocol got=%0d bad cycles exp=0", pb); end
  endtask

  task automatic test_xor_partial();
    logic [DW-1:0] av [6] = '{32'hFF, 32'h0F, 32'hF0, 32'h01, 32'h02, 32'h03};
    logic [DW-1:0] exp_c [6] = '{32'hF0, 32'h00, 32'hFF, 32'h0E, 32'h0D, 32'h0C};
    int dc, pb, nbad;
    logic er;
    fill_img();
    for (int i = 0; i < 6; i++) begin img[i] = av[i]; img[8 + i] = 32'h0F; end
    load_ram();
    run_cmd(1, 6, 0, 8, 16, 0, dc, er, pb);
    checks++; if (dc !== 7) begin failures++; $display("FAIL xor_done_cycle got=%0d exp=7", dc); end
    nbad = 0;
    for (int i = 0; i < 6; i++) if (ram[16 + i] !== exp_c[i]) nbad++;
    checks++; if (nbad != 0) begin failures++; $display("FAIL xor_ram got=%0d wrong words exp=0", nbad); end
    checks++; if (ram[22] !== img[22] || ram[23] !== img[23]) begin failures++; $display("FAIL xor_untouched got=%h,%h exp=%h,%h", ram[22], ram[23], img[22], img[23]); end
    checks++; if (pb != 0 || obs_q.size() != 6) begin failures++; $display("FAIL xor_lanes got=%0d bad cycles %0d writes exp=0,6", pb, obs_q.size()); end
  endtask

  task automatic test_add_wrap();
    int dc, pb;
    logic er;
    fill_img();
    img[0] = 32'hFFFF_FFFF;
    img[8] = 32'd2;
    load_ram();
    run_cmd(2, 1, 0, 8, 16, 0, dc, er, pb);
    checks++; if (ram[16] !== 32'd1) begin failures++; $display("FAIL add_wrap got=%h exp=1", ram[16]); end
    checks++; if (dc !== 4 || er !== 1'b0 || pb != 0) begin failures++; $display("FAIL add_timing got=%0d/%b/%0d exp=4/0/0", dc, er, pb); end
  endtask

  task automatic test_errors();
    int em [4] = '{3, 0, 1, 2};
    int el [4] = '{4, 9, 0, 9};
    logic ee [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    int dc, pb, nbad;
    logic er;
    fill_img();
    load_ram();
    for (int t = 0; t < 4; t++) begin
      run_cmd(em[t], el[t], 0, 8, 16, 0, dc, er, pb);
      checks++; if (dc !== 1 || er !== ee[t]) begin failures++; $display("FAIL err_case%0d got=cycle %0d err %b exp=cycle 1 err %b", t, dc, er, ee[t]); end
      checks++; if (pb != 0 || obs_q.size() != 0) begin failures++; $display("FAIL err_noaccess%0d got=%0d bad %0d writes exp=0,0", t, pb, obs_q.size()); end
    end
    nbad = 0;
    for (int a = 0; a < DEPTH; a++) if (ram[a] !== img[a]) nbad++;
    checks++; if (nbad != 0) begin failures++; $display("FAIL err_ram got=%0d changed words exp=0", nbad); end
  endtask

  task automatic test_reset_mid();
    bit seen_done;
    int dc, edc, pb, nbad;
    logic er, eer;
    fill_img();
    load_ram();
    seen_done = 1'b0;
    @(negedge clk);
    drive_cmd(1, 8, 0, 8, 16, 0);
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int cyc = 1; cyc <= 5; cyc++) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen_done = 1'b1;
      if (cyc == 5) reset = 1'b1;
    end
    @(negedge clk);
    checks++; if (bus.ready !== 1'b1 || bus.done !== 1'b0 || bus.error !== 1'b0 || dbg_state !== IDLE) begin
      failures++; $display("FAIL rstmid_ctrl got=rdy %b done %b err %b st %0d exp=1 0 0 0", bus.ready, bus.done, bus.error, dbg_state); end
    checks++; if (bus.we_n !== '1 || bus.address !== '0 || bus.data_wr !== '0) begin
      failures++; $display("FAIL rstmid_bus got=%b/%h/%h exp=ones/0/0", bus.we_n, bus.address, bus.data_wr); end
    reset = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen_done = 1'b1;
    end
    checks++; if (seen_done) begin failures++; $display("FAIL rstmid_nodone got=1 exp=0"); end
    nbad = 0;
    for (int i = 0; i < 4; i++) if (ram[16 + i] !== (img[i] ^ img[8 + i])) nbad++;
    for (int i = 4; i < 8; i++) if (ram[16 + i] !== img[16 + i]) nbad++;
    checks++; if (nbad != 0) begin failures++; $display("FAIL rstmid_ram got=%0d wrong words exp=0", nbad); end
    for (int a = 0; a < DEPTH; a++) mem_m[a] = ram[a];
    model_cmd(0, 5, 2, 9, 24, 0, eer, edc);
    run_cmd(0, 5, 2, 9, 24, 0, dc, er, pb);
    checks++; if (dc !== edc || er !== eer || pb != 0 || obs_q != exp_q) begin
      failures++; $display("FAIL rstmid_after got=%0d/%b/%0d exp=%0d/%b/0", dc, er, pb, edc, eer); end
  endtask

  task automatic test_back_to_back();
    int d1, d2;
    logic r5, r6;
    fill_img();
    for (int i = 0; i < 4; i++) begin img[i] = DW'(i + 1); img[8 + i] = DW'(i + 5); end
    load_ram();
    d1 = -1; d2 = -1; r5 = 1'bx; r6 = 1'bx;
    @(negedge clk);
    drive_cmd(0, 4, 0, 8, 16, 0);
    @(posedge clk);
    for (int cyc = 1; cyc <= 14; cyc++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        if (d1 < 0) d1 = cyc;
        else if (d2 < 0) d2 = cyc;
      end
      if (cyc == 5) r5 = bus.ready;
      if (cyc == 6) begin r6 = bus.ready; bus.start = 1'b0; end
    end
    checks++; if (d1 !== 4 || d2 !== 9) begin failures++; $display("FAIL b2b_done got=%0d,%0d exp=4,9", d1, d2); end
    checks++; if (r5 !== 1'b1 || r6 !== 1'b0) begin failures++; $display("FAIL b2b_ready got=%b,%b exp=1,0", r5, r6); end
    checks++; if (ram[19] !== 32'd32) begin failures++; $display("FAIL b2b_ram got=%0d exp=32", ram[19]); end
  endtask

  task automatic test_random();
    int m, len, a, b, c, s, dc, edc, pb, nbad;
    logic er, eer;
    for (int t = 0; t < 40; t++) begin
      if (t % 4 == 0) begin fill_img(); load_ram(); end
      m   = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
      len = $urandom_range(0, 9);
      a   = $urandom_range(0, DEPTH - 1);
      b   = $urandom_range(0, DEPTH - 1);
      c   = $urandom_range(0, DEPTH - 1);
      s   = $urandom_range(0, 9);
      model_cmd(m, len, a, b, c, s, eer, edc);
      run_cmd(m, len, a, b, c, s, dc, er, pb);
      checks++; if (dc !== edc || er !== eer) begin failures++; $display("FAIL rand%0d_done got=cycle %0d err %b exp=cycle %0d err %b", t, dc, er, edc, eer); end
      checks++; if (pb != 0) begin failures++; $display("FAIL rand%0d_protocol got=%0d bad cycles exp=0", t, pb); end
      nbad = (obs_q.size() != exp_q.size()) ? 1 : 0;
      if (nbad == 0) foreach (exp_q[w]) if (obs_q[w] !== exp_q[w]) nbad++;
      checks++; if (nbad != 0) begin failures++; $display("FAIL rand%0d_writes got=%0d writes exp=%0d (%0d differ)", t, obs_q.size(), exp_q.size(), nbad); end
      nbad = 0;
      for (int w = 0; w < DEPTH; w++) if (ram[w] !== mem_m[w]) nbad++;
      checks++; if (nbad != 0) begin failures++; $display("FAIL rand%0d_ram got=%0d wrong words exp=0", t, nbad); end
    end
  endtask

`ifdef HV_BIND_PERMUTE_EN
  task automatic test_permute();
    int dc, pb;
    logic er;
    fill_img();
    for (int i = 0; i < 4; i++) begin img[i] = '0; img[8 + i] = DW'(i + 1); end
    load_ram();
    run_cmd(1, 4, 0, 8, 16, 1, dc, er, pb);
    checks++; if (ram[16] !== 2 || ram[17] !== 3 || ram[18] !== 4 || ram[19] !== 1) begin
      failures++; $display("FAIL perm_ram got=%0d,%0d,%0d,%0d exp=2,3,4,1", ram[16], ram[17], ram[18], ram[19]); end
    checks++; if (dc !== 4 || er !== 1'b0 || pb != 0) begin failures++; $display("FAIL perm_timing got=%0d/%b/%0d exp=4/0/0", dc, er, pb); end
    run_cmd(1, 4, 0, 8, 16, 4, dc, er, pb);
    checks++; if (dc !== 1 || er !== 1'b1 || obs_q.size() != 0) begin failures++; $display("FAIL perm_shift_err got=%0d/%b exp=1/1", dc, er); end
  endtask
`endif

  initial begin
    test_reset();
    test_mul();
    test_xor_partial();
    test_add_wrap();
    test_errors();
    test_reset_mid();
    test_back_to_back();
`ifdef HV_BIND_PERMUTE_EN
    test_permute();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hv_bind_sequencer.md
# hv_bind_sequencer

Parametrised successor to the bind kernel mapper. Executes one hypervector bind, C[i] = op(A[i], B[i]) for i < vec_length, over a NUM_PARALLEL_KERNELS-port shared hypervector RAM. It adds three things: a start/ready handshake, runtime-selectable bind modes, and explicit error reporting. It sits between the HDC command decoder and the dpRAM, one lane per RAM port.

## Interface
- HV_DATA_WIDTH, 32: element width in bits.
- HV_ADDRESS_WIDTH, 5: RAM address width.
- MAX_HYPERVECTOR_LENGTH, 8: largest legal vec_length.
- NUM_PARALLEL_KERNELS, 4: lanes / RAM ports (P).
- clk  in  1: sole clock; all logic on rising edge.
- reset  in  1: synchronous, active-high reset.
- start  in  1: request; accepted on an edge where start && ready.
- ready  out  1: high only in IDLE.
- mode  in  2: 0 MUL (low HV_DATA_WIDTH bits of the product), 1 XOR, 2 ADD (wraps), 3 reserved.
- vec_length  in  HV_ADDRESS_WIDTH+1: element count; sampled at accept.
- hva, hvb, hvc  in  HV_ADDRESS_WIDTH each: base addresses; sampled at accept.
- shift  in  HV_ADDRESS_WIDTH: B rotation amount; sampled at accept; only used under the macro.
- we_n  out  P: per-port active-low write enable.
- address  out  P x HV_ADDRESS_WIDTH: per-port address.
- data_wr  out  P x HV_DATA_WIDTH: per-port write data.
- data_rd  in  P x HV_DATA_WIDTH: per-port read data; 1-cycle read latency.
- done  out  1: one-cycle pulse at end of every accepted command.
- error  out  1: valid only while done is high.

## Operation
- FSM states: IDLE, RD_A, RD_B, WR, DONE.
- Accept: all command inputs are latched. The chunk counter k is cleared.
- Next state after accept:
  - IDLE -> RD_A normally.
  - IDLE -> DONE if vec_length == 0, vec_length > MAX_HYPERVECTOR_LENGTH, or mode == 3.
  - In those error/empty cases no RAM access occurs. error = 1, except vec_length == 0 with a legal mode gives error = 0.
- Chunk count C = ceil(vec_length/P). Lane j in chunk k handles element i = k*P + j.
- RD_A: address[j] = hva + i.
- RD_B: address[j] = hvb + i_b. data_rd (A) is registered into a_reg[j].
- WR: address[j] = hvc + i, we_n[j] = 0, data_wr[j] = op(a_reg[j], data_rd[j]).
- After WR: go to RD_A with k+1 if k+1 < C, else go to DONE.
- DONE lasts one cycle, then IDLE.
- Lanes with i >= vec_length: we_n = 1, address = 0, data_wr = 0.
- Address sums wrap modulo 2^HV_ADDRESS_WIDTH. No overlap checking; hvc aliasing hva or hvb is legal because each element is read before it is written.
- address, we_n and data_wr are combinational from the state and registered operands.
- start is ignored when ready = 0. Commands are never queued.
- reset at any point, mid-command included:
  - state goes to IDLE, all registers clear, the in-progress command is abandoned;
  - no done pulse for the abandoned command;
  - a write already performed in an earlier WR stays in RAM.
- Reset values: ready 1, done 0, error 0, we_n all 1, address all 0, data_wr all 0.

## Timing
- Accept edge T0. RD_A occupies cycle 1 after T0, RD_B cycle 2, WR cycle 3; later chunks repeat this every 3 cycles.
- done is high in cycle 3C+1 after T0. For error or empty commands, done is high in cycle 1.
- ready is low from cycle 1 through the done cycle, and high the cycle after done.
- A start held high therefore re-accepts on the edge ending the first ready cycle.
- Each lane's write commits on the edge ending its WR cycle.

## Configuration
- HV_BIND_PERMUTE_EN defined: i_b = (i + shift) mod vec_length, which binds A against a cyclically rotated B.
  - Requires shift < vec_length. If shift >= vec_length at accept, the command is an error (no access, error = 1).
- HV_BIND_PERMUTE_EN undefined: i_b = i. The shift port still exists but is ignored, so instantiations do not change between builds.

## Structure
- Package hv_bind_pkg holds:
  - bind_mode_e enum (MUL, XOR, ADD, RSVD);
  - state_e enum;
  - a function computing ceil-div chunk count.
- Sub-module hv_bind_alu: one combinational lane, op(a, b, mode), instantiated P times through generate.
- RTL sizing: top 200-300 lines, ALU about 40 lines.

## Test plan
- All tests use P = 4, MAX = 8, hva = 0, hvb = 8, hvc = 16.
- MUL, L = 4: A = {1,2,3,4}, B = {5,6,7,8} -> RAM[16..19] = {5,12,21,32}; done in cycle 4 after T0; error = 0.
- XOR, L = 6: A = {FF,0F,F0,1,2,3}, B = all 0F -> RAM[16..21] = {F0,00,FF,0E,0D,0C}; lanes 2-3 of chunk 1 keep we_n = 1; RAM[22..23] untouched; done in cycle 7.
- ADD wrap: A[0] = FFFFFFFF, B[0] = 2, L = 1 -> RAM[16] = 1.
- Error cases: mode = 3, or L = 9, -> done in cycle 1 with error = 1 and no we_n low. L = 0 -> done in cycle 1 with error = 0.
- reset asserted in cycle 5 of an L = 8 command -> outputs return to reset values next cycle; chunk 0 results present in RAM, chunk 1 results absent; no done pulse; a new command completes normally afterwards.
- With HV_BIND_PERMUTE_EN, XOR, L = 4, shift = 1: A = 0, B = {1,2,3,4} -> RAM[16..19] = {2,3,4,1}. shift = 4 -> error = 1.
